// File: rtl/fp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_seq_pkg
//  Purpose  : Shared types and constants for the fp_vec_sub_seq sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package fp_seq_pkg;

   localparam int DW_DEF       = 64;
   localparam int VLEN_MAX_DEF = 16;

   // Cycles after reset during which an unexpected finish is tolerated,
   // so that results from an aborted job cannot raise the sticky error.
   localparam int GATE_CYCLES  = 64;

   localparam logic [63:0] FP_ZERO = 64'h0000_0000_0000_0000;
   localparam logic [63:0] FP_ONE  = 64'h3FF0_0000_0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_seq_inflight_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : fp_seq_inflight_ctr
//  Purpose  : Issue/return counters, in-flight limit and spurious-finish
//             detection for the vector subtract sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module fp_seq_inflight_ctr
   import fp_seq_pkg::*;
#(
   parameter int IDXW         = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          issue,
   input  logic          finish,
   output logic [IDXW:0] iss_cnt,
   output logic [IDXW:0] ret_cnt,
   output logic          can_issue,
   output logic          fin_ok,
   output logic          err_spurious
);

   localparam int             CW    = IDXW + 1;
   localparam logic [CW-1:0]  MAX_C = CW'(MAX_INFLIGHT);

   logic [CW-1:0] inflight;
   logic [6:0]    gate_cnt;
   logic          armed;

   assign inflight  = iss_cnt - ret_cnt;
   assign can_issue = (inflight < MAX_C);
   // A finish only counts as a result when something is outstanding.
   assign fin_ok    = finish && (inflight != '0);
   assign armed     = (gate_cnt == 7'(GATE_CYCLES));

   // Issue and return counters; both may step in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_cnt <= '0;
         ret_cnt <= '0;
      end else if (clr) begin
         iss_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (issue)  iss_cnt <= iss_cnt + CW'(1);
         if (fin_ok) ret_cnt <= ret_cnt + CW'(1);
      end
   end

   // Post-reset window counter that arms the spurious-finish check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      gate_cnt <= '0;
      else if (!armed) gate_cnt <= gate_cnt + 7'd1;
   end

   // Sticky error on a finish with nothing in flight once armed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    err_spurious <= 1'b0;
      else if (finish && (inflight == '0) && armed)  err_spurious <= 1'b1;
   end

endmodule
`default_nettype wire

// File: rtl/fp_vec_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_vec_sub_seq
//  Purpose  : Element-wise vector subtract sequencer r[i] = a[i] - b[i],
//             feeding the fp_suber wrapper and collecting in-order results.
//  Options  : FP_VEC_SUB_PERF_EN enables the perf_cycles job-length counter.
//  Revision : 1.0  initial release
// ============================================================================
module fp_vec_sub_seq
   import fp_seq_pkg::*;
#(
   parameter int DW           = DW_DEF,
   parameter int VLEN_MAX     = VLEN_MAX_DEF,
   parameter int IDXW         = $clog2(VLEN_MAX),
   parameter int MAX_INFLIGHT = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [IDXW:0]   len,
   output logic            busy,
   output logic            done,
   output logic            rd_en,
   output logic [IDXW-1:0] rd_idx,
   input  logic [DW-1:0]   rd_a,
   input  logic [DW-1:0]   rd_b,
   output logic            sub_valid,
   input  logic            sub_ready,
   output logic [DW-1:0]   sub_a,
   output logic [DW-1:0]   sub_b,
   input  logic            sub_finish,
   input  logic [DW-1:0]   sub_result,
   output logic            wr_en,
   output logic [IDXW-1:0] wr_idx,
   output logic [DW-1:0]   wr_data,
   output logic            err_spurious,
   output logic [31:0]     perf_cycles
);

   localparam int            CW     = IDXW + 1;
   localparam logic [CW-1:0] VLEN_C = CW'(VLEN_MAX);

   state_t        state, state_nx;
   logic [CW-1:0] len_r, len_clamp;
   logic [CW-1:0] iss_cnt, ret_cnt, ret_next;
   logic          can_issue, fin_ok;
   logic          start_ok, job_go, hs;

   assign start_ok  = (state == ST_IDLE) && start;
   assign job_go    = start_ok && (len != '0);
   assign hs        = (state == ST_ISSUE) && sub_ready;
   assign len_clamp = (len > VLEN_C) ? VLEN_C : len;
   // Return count including a result arriving this cycle, so done can
   // follow the final write by exactly one cycle.
   assign ret_next  = ret_cnt + CW'(fin_ok);

   fp_seq_inflight_ctr #(
      .IDXW         (IDXW),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) u_ctr (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (job_go),
      .issue        (hs),
      .finish       (sub_finish),
      .iss_cnt      (iss_cnt),
      .ret_cnt      (ret_cnt),
      .can_issue    (can_issue),
      .fin_ok       (fin_ok),
      .err_spurious (err_spurious)
   );

   assign busy    = (state != ST_IDLE);
   assign rd_idx  = iss_cnt[IDXW-1:0];
   assign wr_en   = fin_ok;
   assign wr_idx  = ret_cnt[IDXW-1:0];
   assign wr_data = fin_ok ? sub_result : '0;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_nx  = state;
      rd_en     = 1'b0;
      sub_valid = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = (len == '0) ? ST_DONE : ST_FETCH;
         end
         ST_FETCH: begin
            if (can_issue) begin
               rd_en    = 1'b1;
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nx = ST_ISSUE;
         end
         ST_ISSUE: begin
            sub_valid = 1'b1;
            if (sub_ready)
               state_nx = ((iss_cnt + CW'(1)) < len_r) ? ST_FETCH : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (ret_next == len_r) state_nx = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Length capture on an accepted non-empty start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      len_r <= '0;
      else if (job_go) len_r <= len_clamp;
   end

   // Operand registers, held stable through any ready backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_a <= '0;
         sub_b <= '0;
      end else if (state == ST_LOAD) begin
         sub_a <= rd_a;
         sub_b <= rd_b;
      end
   end

`ifdef FP_VEC_SUB_PERF_EN
   logic [31:0] perf_r;

   // Counts busy cycles of the current job, saturating, cleared on start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  perf_r <= '0;
      else if (start_ok)                           perf_r <= '0;
      else if (busy && (perf_r != 32'hFFFF_FFFF))  perf_r <= perf_r + 32'd1;
   end

   assign perf_cycles = perf_r;
`else
   assign perf_cycles = '0;
`endif

endmodule
`default_nettype wire
